// File: rtl/keccak_absorb_ctrl.sv
// Keccak absorb controller: pulls message lanes from an upstream FIFO,
// numbers them within each rate block, appends SHA-3 padding (0x06 ... 0x80),
// and starts one Keccak-f[1600] permutation per completed block.
module keccak_absorb_ctrl #(
  parameter int RATE_LANES = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] nlanes,
  input  logic        fifo_empty,
  input  logic [63:0] fifo_dout,
  output logic        fifo_rd_en,
  output logic        lane_valid,
  output logic [4:0]  lane_idx,
  output logic [63:0] lane_data,
  output logic        perm_start,
  input  logic        perm_done,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] LAST_IDX = 5'(RATE_LANES - 1);
  localparam logic [5:0] RATE_W   = 6'(RATE_LANES);

  typedef enum logic [2:0] {
    IDLE,
    ABSORB,
    PAD,
    PERM_GO,
    PERM_WAIT,
    FINISH
  } state_t;

  state_t      state_q;
  logic [15:0] total_q;
  logic [16:0] msg_reads_q;
  logic [5:0]  blk_reads_q;
  logic [4:0]  idx_q;
  logic [4:0]  pad_k_q;
  logic        rd_pend_q;
  logic        padded_q;
  logic        perm_start_q;
  logic        busy_q;
  logic        done_q;

  logic        rd_en_w;
  logic        msg_done_w;
  logic [63:0] pad_data_w;

  // The FIFO is popped only while absorbing, only when it has data, and only
  // while both the current block and the whole message still need lanes.
  always_comb begin
    rd_en_w    = (state_q == ABSORB) && !fifo_empty &&
                 (blk_reads_q < RATE_W) && (msg_reads_q < {1'b0, total_q});
    msg_done_w = (msg_reads_q == {1'b0, total_q});
  end

  // Padding lane value: 0x06 lands on the first free lane, the top bit on the
  // last rate lane, and both merge when they coincide.
  always_comb begin
    pad_data_w = '0;
    if (state_q == PAD) begin
      if (idx_q == pad_k_q) begin
        pad_data_w = pad_data_w | 64'h0000_0000_0000_0006;
      end
      if (idx_q == LAST_IDX) begin
        pad_data_w = pad_data_w | 64'h8000_0000_0000_0000;
      end
    end
  end

  assign fifo_rd_en = rd_en_w;
  assign lane_valid = rd_pend_q || (state_q == PAD);
  assign lane_idx   = idx_q;
  assign lane_data  = rd_pend_q ? fifo_dout : pad_data_w;
  assign perm_start = perm_start_q;
  assign busy       = busy_q;
  assign done       = done_q;

  // Main control FSM: read/deliver message lanes, pad the tail block, and
  // hand each full block to the permutation core.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      total_q      <= '0;
      msg_reads_q  <= '0;
      blk_reads_q  <= '0;
      idx_q        <= '0;
      pad_k_q      <= '0;
      rd_pend_q    <= 1'b0;
      padded_q     <= 1'b0;
      perm_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            total_q     <= nlanes;
            msg_reads_q <= '0;
            blk_reads_q <= '0;
            idx_q       <= '0;
            pad_k_q     <= '0;
            rd_pend_q   <= 1'b0;
            padded_q    <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= ABSORB;
          end
        end

        ABSORB: begin
          rd_pend_q <= rd_en_w;
          if (rd_en_w) begin
            msg_reads_q <= msg_reads_q + 17'd1;
            blk_reads_q <= blk_reads_q + 6'd1;
          end
          if (rd_pend_q) begin
            if (idx_q == LAST_IDX) begin
              perm_start_q <= 1'b1;
              state_q      <= PERM_GO;
            end else if (msg_done_w) begin
              idx_q   <= idx_q + 5'd1;
              pad_k_q <= idx_q + 5'd1;
              state_q <= PAD;
            end else begin
              idx_q <= idx_q + 5'd1;
            end
          end else if (msg_done_w) begin
            pad_k_q <= idx_q;
            state_q <= PAD;
          end
        end

        PAD: begin
          if (idx_q == LAST_IDX) begin
            padded_q     <= 1'b1;
            perm_start_q <= 1'b1;
            state_q      <= PERM_GO;
          end else begin
            idx_q <= idx_q + 5'd1;
          end
        end

        PERM_GO: begin
          perm_start_q <= 1'b0;
          state_q      <= PERM_WAIT;
        end

        PERM_WAIT: begin
          if (perm_done) begin
            if (padded_q) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= FINISH;
            end else begin
              blk_reads_q <= '0;
              idx_q       <= '0;
              state_q     <= ABSORB;
            end
          end
        end

        FINISH: begin
          done_q  <= 1'b0;
          idx_q   <= '0;
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keccak_absorb_ctrl.sv
// Self-checking bench for keccak_absorb_ctrl: a behavioural FIFO feeds
// random message lanes, and the expected lane stream is built block by block
// from the SHA-3 padding rule.
module tb_keccak_absorb_ctrl;

  localparam int RATE = 17;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] nlanes = '0;
  logic        fifo_empty = 1'b1;
  logic [63:0] fifo_dout = '0;
  logic        fifo_rd_en;
  logic        lane_valid;
  logic [4:0]  lane_idx;
  logic [63:0] lane_data;
  logic        perm_start;
  logic        perm_done = 1'b0;
  logic        busy;
  logic        done;

  logic        fifoWr = 1'b0;
  logic [63:0] fifoWdata = '0;
  logic        fifoFlush = 1'b0;
  logic [63:0] fifoQ[$];

  int vectors = 0;
  int miscompares = 0;

  keccak_absorb_ctrl #(.RATE_LANES(RATE)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .nlanes     (nlanes),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .lane_valid (lane_valid),
    .lane_idx   (lane_idx),
    .lane_data  (lane_data),
    .perm_start (perm_start),
    .perm_done  (perm_done),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Upstream synchronous FIFO with registered read data and empty flag.
  always @(posedge clk) begin
    if (fifoFlush) begin
      fifoQ.delete();
    end else begin
      if (fifo_rd_en && fifoQ.size() > 0) fifo_dout <= fifoQ.pop_front();
      if (fifoWr) fifoQ.push_back(fifoWdata);
    end
    fifo_empty <= (fifoQ.size() == 0);
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_fifo_rd_en"}, 64'(fifo_rd_en), 64'd0);
    checkOutput({tag, "_lane_valid"}, 64'(lane_valid), 64'd0);
    checkOutput({tag, "_lane_idx"},   64'(lane_idx),   64'd0);
    checkOutput({tag, "_lane_data"},  lane_data,       64'd0);
    checkOutput({tag, "_perm_start"}, 64'(perm_start), 64'd0);
    checkOutput({tag, "_busy"},       64'(busy),       64'd0);
    checkOutput({tag, "_done"},       64'(done),       64'd0);
  endtask

  // Run one message: n lanes, prefill lanes written before start, the rest
  // one every gap cycles; the permutation answers permDelay cycles after
  // perm_start. rstAtIdx >= 0 aborts with a reset when that lane index shows.
  task automatic applyStimulus(input int n, input int prefill, input int gap,
                               input int permDelay, input bit secondStart,
                               input int rstAtIdx, input int expRun);
    logic [63:0] msg[$];
    logic [63:0] expData[$];
    int          expIdx[$];
    logic [63:0] d;
    int numBlocks, lanesSeen, permStarts, waitLeft, writeIdx, run, maxRun, g;
    bit prevRd, finished;

    numBlocks = n / RATE + 1;
    for (int i = 0; i < n; i++) msg.push_back({$urandom, $urandom});
    for (int b = 0; b < numBlocks; b++) begin
      for (int j = 0; j < RATE; j++) begin
        g = b * RATE + j;
        if (g < n) begin
          d = msg[g];
        end else begin
          d = 64'd0;
          if (g == n) d = d | 64'h6;
          if (j == RATE - 1) d = d | 64'h8000_0000_0000_0000;
        end
        expData.push_back(d);
        expIdx.push_back(j);
      end
    end

    writeIdx = 0;
    while (writeIdx < prefill && writeIdx < n) begin
      @(negedge clk);
      fifoWr = 1'b1;
      fifoWdata = msg[writeIdx];
      writeIdx++;
    end
    @(negedge clk);
    fifoWr = 1'b0;
    start = 1'b1;
    nlanes = 16'(n);

    lanesSeen = 0; permStarts = 0; waitLeft = 0; run = 0; maxRun = 0;
    prevRd = 1'b0; finished = 1'b0;
    if (gap < 1) gap = 1;

    for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      fifoWr = 1'b0;
      perm_done = 1'b0;

      if (fifo_rd_en) checkOutput("rd_while_empty", 64'(fifo_empty), 64'd0);
      if (prevRd) checkOutput("read_latency", 64'(lane_valid), 64'd1);
      if (waitLeft > 0) begin
        checkOutput("wait_lane_valid", 64'(lane_valid), 64'd0);
        checkOutput("wait_rd_en", 64'(fifo_rd_en), 64'd0);
      end
      if (lane_valid) begin
        if (lanesSeen < expData.size()) begin
          checkOutput($sformatf("lane%0d_idx", lanesSeen), 64'(lane_idx), 64'(expIdx[lanesSeen]));
          checkOutput($sformatf("lane%0d_data", lanesSeen), lane_data, expData[lanesSeen]);
          if (lanesSeen < n) checkOutput("msg_lane_after_read", 64'(prevRd), 64'd1);
        end else begin
          checkOutput("extra_lane", 64'(lanesSeen), 64'(expData.size()));
        end
        lanesSeen++;
      end

      if (rstAtIdx >= 0 && lane_valid && int'(lane_idx) == rstAtIdx) begin
        rst = 1'b1;
        #1;
        checkAllZero("reset_mid_msg");
        @(negedge clk);
        rst = 1'b0;
        fifoFlush = 1'b1;
        @(negedge clk);
        fifoFlush = 1'b0;
        return;
      end

      if (fifo_rd_en) run++; else run = 0;
      if (run > maxRun) maxRun = run;
      prevRd = fifo_rd_en;

      if (perm_start) begin
        permStarts++;
        waitLeft = permDelay;
      end else if (waitLeft > 0) begin
        waitLeft--;
        if (waitLeft == 0) perm_done = 1'b1;
      end

      if (done) begin
        checkOutput("busy_low_at_done", 64'(busy), 64'd0);
        checkOutput("lanes_before_done", 64'(lanesSeen), 64'(expData.size()));
        checkOutput("perm_start_count", 64'(permStarts), 64'(numBlocks));
        finished = 1'b1;
      end else begin
        checkOutput("busy_held", 64'(busy), 64'd1);
      end

      if (secondStart && cyc == 6) begin
        start = 1'b1;
        nlanes = 16'd5;
      end
      if (writeIdx < n && (cyc % gap) == 0) begin
        fifoWr = 1'b1;
        fifoWdata = msg[writeIdx];
        writeIdx++;
      end
    end

    checkOutput("done_within_budget", 64'(finished), 64'd1);
    perm_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("done_single", 64'(done), 64'd0);
      checkOutput("idle_busy", 64'(busy), 64'd0);
    end
    if (expRun > 0) checkOutput("rd_burst_len", 64'(maxRun), 64'(expRun));
  endtask

  initial begin
    int n;
    $display("[TB] keccak_absorb_ctrl bench, RATE=%0d", RATE);
    rst = 1'b1;
    #1;
    checkAllZero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Empty message: padding-only block.
    applyStimulus(0, 0, 1, 2, 1'b0, -1, 0);
    // 16 prefilled lanes: one message block with merged padding.
    applyStimulus(16, 16, 1, 3, 1'b0, -1, 16);
    // Exactly one full block, then a padding-only block.
    applyStimulus(17, 17, 1, 1, 1'b0, -1, 17);
    // Slow producer.
    applyStimulus(3, 0, 5, 2, 1'b0, -1, 0);
    // Long permutation with an ignored second start.
    applyStimulus(20, 10, 2, 20, 1'b1, -1, 0);
    // Two full blocks plus padding block.
    applyStimulus(34, 30, 1, 4, 1'b0, -1, 0);
    // Random lengths and pacing.
    for (int t = 0; t < 4; t++) begin
      n = int'($urandom_range(0, 60));
      applyStimulus(n, int'($urandom_range(0, n)), int'($urandom_range(1, 3)),
                    int'($urandom_range(1, 6)), 1'b0, -1, 0);
    end
    // Reset in the middle of a block, then a normal empty message.
    applyStimulus(12, 12, 1, 2, 1'b0, 8, 0);
    applyStimulus(0, 0, 1, 2, 1'b0, -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
